// File: rtl/hex_display_ctrl_if.sv
// Nios-style register bus between the processor and the hex display driver.
interface hex_display_ctrl_if;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;

  modport master (
    output address, write, writedata, read,
    input  readdata
  );

  modport slave (
    input  address, write, writedata, read,
    output readdata
  );
endinterface

// File: rtl/hex_display_ctrl.sv
// Active-low 7-segment driver with blank/blink masks and power-on lamp test; HEX_DP_EN adds decimal points.
// Latency: zero-wait writes, readdata one cycle after read, hex_n one cycle after a register update; backpressure: none.
module hex_display_ctrl #(
  parameter int NUM_DIGITS       = 8,
  parameter int BLINK_DIV        = 25000000,
  parameter int LAMP_TEST_CYCLES = 50000000,
`ifdef HEX_DP_EN
  localparam int SEG_W = 8
`else
  localparam int SEG_W = 7
`endif
) (
  input  logic                        clk_0,
  input  logic                        reset,
  hex_display_ctrl_if.slave           bus,
  output logic [NUM_DIGITS*SEG_W-1:0] hex_n
);

  localparam int LW        = (LAMP_TEST_CYCLES > 1) ? $clog2(LAMP_TEST_CYCLES) : 1;
  localparam int BW        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int LAMP_LAST = (LAMP_TEST_CYCLES > 0) ? LAMP_TEST_CYCLES - 1 : 0;
  localparam int BLINK_LAST = BLINK_DIV - 1;

  typedef enum logic {LAMP = 1'b0, RUN = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic [LW-1:0]             lamp_cnt_q, lamp_cnt_d;
  logic [BW-1:0]             blink_cnt_q;
  logic                      phase_q;
  logic [NUM_DIGITS*4-1:0]   data_q;
  logic [NUM_DIGITS-1:0]     blank_q;
  logic [NUM_DIGITS-1:0]     blink_q;
  logic                      force_lamp_q;
  logic                      blink_en_q;
  logic [NUM_DIGITS-1:0]     dp_q;
  logic [31:0]               ctrl_rd;
  logic [NUM_DIGITS*SEG_W-1:0] hex_d;
  logic                      restart;
  logic                      lamp_on;

  assign restart = bus.write && (bus.address == 2'd3) && bus.writedata[2];
  assign lamp_on = (state_q == LAMP) || force_lamp_q;

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Lamp-test FSM; a restart pulse wins over the end-of-count transition.
  always_comb begin
    state_d    = state_q;
    lamp_cnt_d = lamp_cnt_q;
    if (restart) begin
      state_d    = LAMP;
      lamp_cnt_d = '0;
    end else if (state_q == LAMP) begin
      if (LAMP_TEST_CYCLES == 0 || lamp_cnt_q == LW'(LAMP_LAST)) begin
        state_d    = RUN;
        lamp_cnt_d = '0;
      end else begin
        lamp_cnt_d = lamp_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_0 or posedge reset) begin
    if (reset) begin
      state_q    <= LAMP;
      lamp_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lamp_cnt_q <= lamp_cnt_d;
    end
  end

  always_ff @(posedge clk_0 or posedge reset) begin
    if (reset) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (!blink_en_q) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (blink_cnt_q == BW'(BLINK_LAST)) begin
      blink_cnt_q <= '0;
      phase_q     <= ~phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_0 or posedge reset) begin
    if (reset) begin
      data_q       <= '0;
      blank_q      <= '0;
      blink_q      <= '0;
      force_lamp_q <= 1'b0;
      blink_en_q   <= 1'b0;
      dp_q         <= '0;
    end else if (bus.write) begin
      case (bus.address)
        2'd0: data_q  <= bus.writedata[NUM_DIGITS*4-1:0];
        2'd1: blank_q <= bus.writedata[NUM_DIGITS-1:0];
        2'd2: blink_q <= bus.writedata[NUM_DIGITS-1:0];
        default: begin
          force_lamp_q <= bus.writedata[0];
          blink_en_q   <= bus.writedata[1];
`ifdef HEX_DP_EN
          dp_q         <= bus.writedata[8 +: NUM_DIGITS];
`endif
        end
      endcase
    end
  end

  always_comb begin
    ctrl_rd    = '0;
    ctrl_rd[0] = force_lamp_q;
    ctrl_rd[1] = blink_en_q;
    ctrl_rd[3] = (state_q == LAMP);
`ifdef HEX_DP_EN
    ctrl_rd[8 +: NUM_DIGITS] = dp_q;
`endif
  end

  // Registered read; a same-cycle write is not yet visible, so the old value returns.
  always_ff @(posedge clk_0 or posedge reset) begin
    if (reset) begin
      bus.readdata <= '0;
    end else if (bus.read) begin
      case (bus.address)
        2'd0:    bus.readdata <= 32'(data_q);
        2'd1:    bus.readdata <= 32'(blank_q);
        2'd2:    bus.readdata <= 32'(blink_q);
        default: bus.readdata <= ctrl_rd;
      endcase
    end
  end

  always_comb begin
    hex_d = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (lamp_on) begin
        hex_d[k*SEG_W +: SEG_W] = '0;
      end else if (blank_q[k] || (blink_q[k] && phase_q)) begin
        hex_d[k*SEG_W +: SEG_W] = '1;
      end else begin
        hex_d[k*SEG_W +: 7] = hex_decode(data_q[k*4 +: 4]);
`ifdef HEX_DP_EN
        hex_d[k*SEG_W + 7] = ~dp_q[k];
`endif
      end
    end
  end

  always_ff @(posedge clk_0 or posedge reset) begin
    if (reset) begin
      hex_n <= '0;
    end else begin
      hex_n <= hex_d;
    end
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl with a short lamp test and fast blink.
module tb_hex_display_ctrl;

  localparam int ND = 8;

  logic        clk_0 = 1'b0;
  logic        reset = 1'b1;
  logic [55:0] hex_n;
  logic [31:0] rd;
  int          checks = 0;
  int          errors = 0;

  localparam logic [55:0] ALL_ON   = '0;
  localparam logic [55:0] ALL_OFF  = {8{7'h7F}};
  localparam logic [55:0] ALL_ZERO = {8{7'h40}};
  localparam logic [55:0] PAT_89AB = {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  hex_display_ctrl_if bus ();

  hex_display_ctrl #(
    .NUM_DIGITS       (ND),
    .BLINK_DIV        (4),
    .LAMP_TEST_CYCLES (10)
  ) dut (
    .clk_0 (clk_0),
    .reset (reset),
    .bus   (bus),
    .hex_n (hex_n)
  );

  always #5 clk_0 = ~clk_0;

  task automatic tick();
    @(posedge clk_0);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.address   = a;
    bus.writedata = d;
    bus.write     = 1'b1;
    tick();
    bus.write     = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] r);
    bus.address = a;
    bus.read    = 1'b1;
    tick();
    bus.read    = 1'b0;
    r           = bus.readdata;
  endtask

  initial begin
    bus.address   = '0;
    bus.write     = 1'b0;
    bus.writedata = '0;
    bus.read      = 1'b0;

    // Reset state
    tick();
    tick();
    chk("reset_hex", 64'(hex_n), 64'(ALL_ON));
    chk("reset_readdata", 64'(bus.readdata), 64'h0);

    // 1: lamp test after release
    reset = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("lamp_hex_9", 64'(hex_n), 64'(ALL_ON));
    bus_read(2'd3, rd);
    chk("lamp_ctrl", 64'(rd), 64'h8);
    chk("lamp_hex_10", 64'(hex_n), 64'(ALL_ON));
    tick();
    chk("run_hex_zero", 64'(hex_n), 64'(ALL_ZERO));
    bus_read(2'd3, rd);
    chk("run_ctrl", 64'(rd), 64'h0);

    // 2: data decode and readback
    bus_write(2'd0, 32'h89AB_CDEF);
    chk("data_latency", 64'(hex_n), 64'(ALL_ZERO));
    tick();
    chk("data_decode", 64'(hex_n), 64'(PAT_89AB));
    bus_read(2'd0, rd);
    chk("data_read", 64'(rd), 64'h89AB_CDEF);

    // Read and write of the same address in one cycle returns the old value
    bus.address   = 2'd0;
    bus.writedata = 32'h1234_5678;
    bus.write     = 1'b1;
    bus.read      = 1'b1;
    tick();
    bus.write     = 1'b0;
    bus.read      = 1'b0;
    chk("rw_same_old", 64'(bus.readdata), 64'h89AB_CDEF);
    tick();
    chk("rw_new_decode", 64'(hex_n), 64'({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}));
    bus_write(2'd0, 32'h89AB_CDEF);
    bus_write(2'd1, 32'hFFFF_FF01);
    bus_read(2'd1, rd);
    chk("blank_read_mask", 64'(rd), 64'h01);

    // 3: blank digit0, blink digit1 with period 8
    bus_write(2'd2, 32'h02);
    bus_write(2'd3, 32'h2);
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk($sformatf("blink_%0d", i), 64'(hex_n),
          64'({PAT_89AB[55:14], ((((i - 1) / 4) % 2) == 1) ? 7'h7F : 7'h06, 7'h7F}));
    end
    bus_read(2'd3, rd);
    chk("ctrl_blink_en", 64'(rd), 64'h2);

    // 4: force_lamp over blank, then all blanked
    bus_write(2'd1, 32'hFF);
    bus_write(2'd3, 32'h1);
    tick();
    chk("force_lamp", 64'(hex_n), 64'(ALL_ON));
    bus_write(2'd3, 32'h0);
    tick();
    chk("all_blank", 64'(hex_n), 64'(ALL_OFF));

    // 5: restart lamp, then re-restart at count 5
    bus_write(2'd3, 32'h4);
    bus_read(2'd3, rd);
    chk("restart_ctrl", 64'(rd), 64'h8);
    chk("restart_hex_1", 64'(hex_n), 64'(ALL_ON));
    for (int i = 2; i <= 4; i++) tick();
    chk("restart_hex_4", 64'(hex_n), 64'(ALL_ON));
    bus_write(2'd3, 32'h4);
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("relamp_%0d", i), 64'(hex_n), 64'(ALL_ON));
    end
    tick();
    chk("relamp_end", 64'(hex_n), 64'(ALL_OFF));
    bus_read(2'd3, rd);
    chk("relamp_ctrl", 64'(rd), 64'h0);

    // 6: reset mid-blink
    bus_write(2'd1, 32'h0);
    bus_write(2'd2, 32'hFF);
    bus_write(2'd3, 32'h2);
    for (int i = 0; i < 6; i++) tick();
    bus_read(2'd0, rd);
    chk("pre_reset_data", 64'(rd), 64'h89AB_CDEF);
    reset = 1'b1;
    #1;
    chk("async_reset_hex", 64'(hex_n), 64'(ALL_ON));
    chk("async_reset_rd", 64'(bus.readdata), 64'h0);
    tick();
    tick();
    reset = 1'b0;
    bus_read(2'd0, rd);
    chk("post_reset_data", 64'(rd), 64'h0);
    bus_read(2'd3, rd);
    chk("post_reset_ctrl", 64'(rd), 64'h8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
